lsu_mem: RTL
============

Name: lsu_mem

Overview:
- Parametrised, byte-addressable data memory for the core's load/store path; next generation of the single-cycle word/byte-mask data RAM.
- Adds a valid/ready request interface, byte/half/word access decode, sign/zero extension, misalignment error reporting and configurable read latency.
- Adds an optional post-reset clear sequencer.
- Sits between the LSU/execute stage and the word-wide storage bank.

Parameters:
- ADDR_W, 11, byte-address width; capacity 2^ADDR_W bytes, DEPTH = 2^(ADDR_W-2) 32-bit words.
- RD_LAT, 1, response latency in cycles after request acceptance; legal values 1 or 2.
- CLEAR_ON_RST, 1, when 1 the memory is zeroed word-by-word after reset before accepting requests.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  request can be accepted.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_addr  in  ADDR_W  byte address.
- i_req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- i_req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- i_req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- o_rsp_valid  out  1  one-cycle response pulse.
- o_rsp_rdata  out  32  extended load data; 0 for stores and errors.
- o_rsp_err  out  1  misaligned or illegal-size request.
- o_busy  out  1  clear sequence in progress.

Behaviour:
- Clocking and reset: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset values: o_req_ready = 0, o_rsp_valid = 0, o_rsp_rdata = 0, o_rsp_err = 0, o_busy = CLEAR_ON_RST, clear counter = 0. All in-flight responses are discarded.
- FSM states: CLEAR, RUN.
  - Reset enters CLEAR if CLEAR_ON_RST = 1, otherwise RUN.
  - CLEAR writes 0 to word[cnt] each cycle and increments cnt. At cnt = DEPTH-1 the state moves to RUN on the next edge, so CLEAR lasts exactly DEPTH cycles.
- Ready and handshake:
  - o_req_ready = (state == RUN); o_busy = (state == CLEAR).
  - A request is accepted on a rising edge with i_req_valid & o_req_ready.
  - Fully pipelined: one request per cycle, no response backpressure.
- Word index and alignment: word index = addr[ADDR_W-1:2]. A request is misaligned when:
  - size = half and addr[0] = 1, or
  - size = word and addr[1:0] != 0, or
  - size = 11.
- Byte lanes:
  - byte: 4'b0001 << addr[1:0].
  - half: 4'b0011 << {addr[1], 1'b0}.
  - word: 4'b1111.
- Stores: write data is replicated across lanes (byte x4, half x2) and written under the lane mask at the accept edge. Misaligned stores write nothing.
- Loads: read the addressed word, select the lane, then sign- or zero-extend to 32 bits.
- Response timing: exactly RD_LAT cycles after acceptance, o_rsp_valid = 1 for one cycle.
  - Load: o_rsp_rdata = extended data.
  - Store: o_rsp_rdata = 0.
  - Error: o_rsp_err = 1 and o_rsp_rdata = 0.
  - Responses stay in request order.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new data. Same-cycle conflicts cannot occur because the interface carries one request per cycle.
- Reset mid-operation: aborts CLEAR and restarts it at cnt = 0, and drops pending responses. Memory contents are undefined until the clear completes, or retained when CLEAR_ON_RST = 0.
- Requests presented while ready = 0 are ignored; no response is produced.

Decomposition:
- lsu_mem_pkg holds:
  - size_e (SZ_B, SZ_H, SZ_W);
  - state_e (CLEAR, RUN);
  - function lane_mask(size, addr_lo);
  - function load_extend(word, size, addr_lo, unsigned);
  - function misaligned(size, addr_lo).
- Sub-module lsu_mem_bank: DEPTH x 32 word RAM with 4-bit byte-enable synchronous write and registered read. lsu_mem adds one extra output register when RD_LAT = 2.

Test Plan:
- Reset, then hold valid = 1 → ready = 0 and busy = 1 for exactly 512 cycles (ADDR_W = 11), then ready = 1. A word load from 0x7FC returns 0x00000000.
- Store word 0xDEADBEEF @0x010, then loads @0x010:
  - lb → 0xFFFFFFEF; lbu → 0x000000EF;
  - lh @0x012 → 0xFFFFDEAD; lhu @0x012 → 0x0000DEAD;
  - responses arrive RD_LAT cycles after each accept.
- Store byte 0x55 @0x013 over 0xDEADBEEF, then load word @0x010 on the very next cycle → 0x55ADBEEF.
- Store half @0x021, load word @0x022, and a size = 11 request → each has o_rsp_err = 1 and rdata = 0. Word @0x020 is unchanged.
- Back-to-back 8 loads with RD_LAT = 2 → 8 consecutive o_rsp_valid pulses, in order, beginning 2 cycles after the first accept.
- Assert i_rst during CLEAR at cnt = 100, and separately with 2 responses in flight → no o_rsp_valid is produced and the clear restarts at cnt = 0.

Source files
------------

// File: rtl/lsu_mem_pkg.sv
// Shared types and access-decode helpers for the LSU data memory.
// Size encoding, FSM states and lane/extension functions live here.
package lsu_mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef struct packed {
    logic       valid;
    logic       we;
    logic       err;
    logic [1:0] size;
    logic [1:0] lo;
    logic       uns;
  } meta_t;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic bad;
    unique case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = lo[0];
      SZ_W:    bad = |lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_mask(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic [3:0] m;
    unique case (size)
      SZ_B:    m = 4'b0001 << lo;
      SZ_H:    m = 4'b0011 << {lo[1], 1'b0};
      SZ_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Right-aligned store data copied into every lane it could land on.
  function automatic logic [31:0] store_align(
    input logic [31:0] wd,
    input logic [1:0]  size
  );
    logic [31:0] r;
    unique case (size)
      SZ_B:    r = {4{wd[7:0]}};
      SZ_H:    r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extend(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic [1:0]  lo,
    input logic        uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = word[{lo[1], 4'b0000} +: 16];
    unique case (size)
      SZ_B:    r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_H:    r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      SZ_W:    r = word;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_mem_bank.sv
// Word-wide storage bank: byte-enable synchronous write,
// registered read of the addressed word.
module lsu_mem_bank #(
  parameter int AW = 9
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  localparam int DEPTH = 1 << AW;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
    o_rdata <= mem[i_addr];
  end

endmodule

// File: rtl/lsu_mem.sv
// Byte-addressable load/store data memory with valid/ready requests,
// sign/zero extension, misalignment errors and optional post-reset clear.
module lsu_mem
  import lsu_mem_pkg::*;
#(
  parameter int ADDR_W       = 11,
  parameter int RD_LAT       = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_busy
);

  localparam int WA_W  = ADDR_W - 2;
  localparam int DEPTH = 1 << WA_W;

  state_e          state;
  logic [WA_W-1:0] cnt;
  meta_t           m1;

  logic            accept;
  logic            req_err;
  logic [1:0]      lo;

  logic            bank_we;
  logic [3:0]      bank_be;
  logic [WA_W-1:0] bank_addr;
  logic [31:0]     bank_wdata;
  logic [31:0]     bank_rdata;

  logic            rsp_valid;
  logic            rsp_err;
  logic [31:0]     rsp_data;

  assign accept  = i_req_valid & o_req_ready;
  assign lo      = i_req_addr[1:0];
  assign req_err = misaligned(i_req_size, lo);

  // The clear sequencer owns the bank port while busy.
  always_comb begin
    bank_we    = 1'b0;
    bank_be    = lane_mask(i_req_size, lo);
    bank_addr  = i_req_addr[ADDR_W-1:2];
    bank_wdata = store_align(i_req_wdata, i_req_size);
    if (state == CLEAR) begin
      bank_we    = 1'b1;
      bank_be    = 4'hF;
      bank_addr  = cnt;
      bank_wdata = '0;
    end else if (accept && i_req_we && !req_err) begin
      bank_we = 1'b1;
    end
  end

  lsu_mem_bank #(
    .AW(WA_W)
  ) u_bank (
    .i_clk   (i_clk),
    .i_we    (bank_we),
    .i_be    (bank_be),
    .i_addr  (bank_addr),
    .i_wdata (bank_wdata),
    .o_rdata (bank_rdata)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= (CLEAR_ON_RST != 0) ? CLEAR : RUN;
      cnt         <= '0;
      o_req_ready <= 1'b0;
      o_busy      <= (CLEAR_ON_RST != 0);
    end else begin
      unique case (state)
        CLEAR: begin
          cnt <= cnt + WA_W'(1);
          if (cnt == WA_W'(DEPTH - 1)) begin
            state       <= RUN;
            o_req_ready <= 1'b1;
            o_busy      <= 1'b0;
          end
        end
        RUN: begin
          o_req_ready <= 1'b1;
          o_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Request attributes travel alongside the bank's registered read.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m1 <= '0;
    end else begin
      m1.valid <= accept;
      m1.we    <= i_req_we;
      m1.err   <= req_err;
      m1.size  <= i_req_size;
      m1.lo    <= lo;
      m1.uns   <= i_req_unsigned;
    end
  end

  assign rsp_valid = m1.valid;
  assign rsp_err   = m1.valid & m1.err;
  assign rsp_data  = (m1.valid && !m1.we && !m1.err)
                   ? load_extend(bank_rdata, m1.size, m1.lo, m1.uns)
                   : '0;

  if (RD_LAT == 2) begin : g_lat2
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        o_rsp_valid <= 1'b0;
        o_rsp_rdata <= '0;
        o_rsp_err   <= 1'b0;
      end else begin
        o_rsp_valid <= rsp_valid;
        o_rsp_rdata <= rsp_data;
        o_rsp_err   <= rsp_err;
      end
    end
  end else begin : g_lat1
    assign o_rsp_valid = rsp_valid;
    assign o_rsp_rdata = rsp_data;
    assign o_rsp_err   = rsp_err;
  end

endmodule
